// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// if_fetch_unit -- PC generation, single-outstanding imem fetch, 2-entry prefetch buffer.
// Revision: 1.0

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  input  logic        load_stop_request,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_PC,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic        head_q;
  logic [1:0]  count_q, count_d;

  logic        w_pop;
  logic        w_push;
  logic        w_tail;
  logic [31:0] w_req_next;
  logic [1:0]  w_cnt_less_pop;
  logic [1:0]  w_cnt_after;

  assign if_valid       = (count_q != 2'd0);
  assign w_pop          = if_valid & ~load_stop_request & ~br_flag;
  assign w_tail         = head_q ^ count_q[0];
  assign w_req_next     = req_addr_q + 32'd4;
  assign w_cnt_less_pop = count_q - {1'b0, w_pop};
  assign w_cnt_after    = w_cnt_less_pop + 2'd1;

  assign imem_req  = (state_q == REQ) || (state_q == DISCARD);
  assign imem_addr = req_addr_q;
  assign if_PC     = if_valid ? fifo_pc_q[head_q]    : pc_q;
  assign if_instr  = if_valid ? fifo_instr_q[head_q] : 32'h0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    w_push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_flag) begin
          pc_d       = br_target;
          req_addr_d = br_target;
          state_d    = REQ;
        end else if (w_cnt_less_pop < 2'd2) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (br_flag) begin
          // With an ack the data is simply dropped and the target is requested next;
          // without one the pending response must be drained first.
          pc_d = br_target;
          if (imem_ack) begin
            req_addr_d = br_target;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          w_push = 1'b1;
          pc_d   = w_req_next;
          if (w_cnt_after < 2'd2) begin
            req_addr_d = w_req_next;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (br_flag) begin
          pc_d = br_target;
        end
        if (imem_ack) begin
          req_addr_d = br_flag ? br_target : pc_q;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (br_flag) begin
      count_d = 2'd0;
    end else if (w_push) begin
      count_d = w_cnt_after;
    end else begin
      count_d = w_cnt_less_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      if (br_flag) begin
        head_q <= 1'b0;
      end else if (w_pop) begin
        head_q <= ~head_q;
      end
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_pc_q[w_tail]    <= req_addr_q;
      fifo_instr_q[w_tail] <= imem_rdata;
    end
  end

  a_no_ack_when_full: assert property (@(posedge clk) disable iff (rst)
    !((state_q == REQ) && imem_ack && (count_q == 2'd2)));

endmodule

`default_nettype wire
